// File: rtl/rst_stream_encrypt.sv
// rtl/rst_stream_encrypt.sv - streaming substitution-table encryptor
// Captures a 7x7 table, then maps each plaintext char to a row/column header pair.
module rst_stream_encrypt (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0][6:0][7:0] sub_char,
    input  logic                 table_err,
    input  logic                 table_load,
    output logic                 table_ready,
    input  logic                 pt_valid,
    input  logic [7:0]           pt_char,
    output logic                 pt_ready,
    output logic                 ct_valid,
    output logic [7:0]           ct_char,
    input  logic                 ct_ready,
    output logic                 err_invalid_pt
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT_ROW, EMIT_COL} state_t;

    state_t               state;
    state_t               state_next;
    logic [6:0][6:0][7:0] tbl;
    logic [7:0]           ch;
    logic [7:0]           folded;
    logic [2:0]           r;
    logic [2:0]           k;
    logic [2:0]           l;
    logic                 hit;
    logic [2:0]           hit_col;
    logic                 accept;

    always_comb begin
        folded = pt_char;
        if (pt_char >= 8'h41 && pt_char <= 8'h5A)
            folded = pt_char + 8'h20;
    end

    // Walk columns high to low so the lowest matching column wins.
    always_comb begin
        hit     = 1'b0;
        hit_col = 3'd1;
        for (int j = 6; j >= 1; j--) begin
            if (tbl[r][j[2:0]] == ch) begin
                hit     = 1'b1;
                hit_col = j[2:0];
            end
        end
    end

    assign accept = (state == IDLE) && pt_valid && pt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = SCAN;
            SCAN:     if (hit) state_next = EMIT_ROW;
                      else if (r == 3'd6) state_next = IDLE;
            EMIT_ROW: if (ct_ready) state_next = EMIT_COL;
            EMIT_COL: if (ct_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        pt_ready = 1'b0;
        ct_valid = 1'b0;
        ct_char  = 8'h00;
        case (state)
            IDLE:     pt_ready = table_ready && !table_load;
            EMIT_ROW: begin
                ct_valid = 1'b1;
                ct_char  = tbl[k][0];
            end
            EMIT_COL: begin
                ct_valid = 1'b1;
                ct_char  = tbl[0][l];
            end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl            <= '0;
            table_ready    <= 1'b0;
            ch             <= 8'h00;
            r              <= 3'd1;
            k              <= 3'd1;
            l              <= 3'd1;
            err_invalid_pt <= 1'b0;
        end else begin
            err_invalid_pt <= (state == SCAN) && !hit && (r == 3'd6);
            if (state == IDLE && table_load) begin
                tbl         <= table_err ? '0 : sub_char;
                table_ready <= !table_err;
            end
            if (accept) begin
                ch <= folded;
                r  <= 3'd1;
            end else if (state == SCAN && !hit && r != 3'd6) begin
                r <= r + 3'd1;
            end
            if (state == SCAN && hit) begin
                k <= r;
                l <= hit_col;
            end
        end
    end

endmodule
